riscv_instruction_encoder: RTL and testbench

- Field-level RV32I instruction encoder and program loader; the encode-side counterpart of the 5-stage control decoder.
- Accepts one instruction per valid/ready handshake as an instruction type plus opcode, funct, register and immediate fields.
- Range-checks the fields, packs them into a 32-bit instruction word and writes it to the next sequential instruction-memory word over a stallable write port.
- Used by testbenches and the boot path to fill instruction memory before the pipeline is released.

---
 rtl/riscv_instruction_encoder.sv | 173 +++++++++++++++++
 tb/tb_riscv_instruction_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instruction_encoder.sv
// RV32I field-level instruction encoder: range-checks typed fields, packs them
// into a 32-bit word and writes it to sequential instruction-memory words.
module riscv_instruction_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_type,
    input  logic [6:0]         in_opcode,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic signed [31:0] in_imm,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ack,
    output logic               err,
    output logic               err_sticky,
    output logic               full,
    output logic [15:0]        count
);

    // riscv_instructionType_* encodings; any other value is undefined
    localparam logic [2:0] TYPE_R  = 3'd0;
    localparam logic [2:0] TYPE_I  = 3'd1;
    localparam logic [2:0] TYPE_S  = 3'd2;
    localparam logic [2:0] TYPE_SB = 3'd3;
    localparam logic [2:0] TYPE_U  = 3'd4;
    localparam logic [2:0] TYPE_UJ = 3'd5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [16:0] DEPTH_CNT = 17'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         type_q;
    logic [6:0]         opcode_q;
    logic [2:0]         funct3_q;
    logic [6:0]         funct7_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic signed [31:0] imm_q;
    logic [16:0]        count_inc;

    function automatic logic fits_signed(input logic signed [31:0] imm,
                                         input int unsigned bits);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (bits - 1);
        return (imm >= -lim) && (imm < lim);
    endfunction

    function automatic logic is_shift(input logic [2:0] t, input logic [6:0] op,
                                      input logic [2:0] f3);
        return (t == TYPE_I) && (op == OPC_OP_IMM) &&
               ((f3 == F3_SLL) || (f3 == F3_SRL_SRA));
    endfunction

    function automatic logic is_legal(input logic [2:0] t, input logic [6:0] op,
                                      input logic [2:0] f3,
                                      input logic signed [31:0] imm);
        logic ok;
        case (t)
            TYPE_R:  ok = 1'b1;
            TYPE_I:  ok = is_shift(t, op, f3) ? (imm[31:5] == '0) : fits_signed(imm, 12);
            TYPE_S:  ok = fits_signed(imm, 12);
            TYPE_SB: ok = fits_signed(imm, 13) && !imm[0];
            TYPE_U:  ok = (imm[11:0] == '0);
            TYPE_UJ: ok = fits_signed(imm, 21) && !imm[0];
            default: ok = 1'b0;
        endcase
        return ok && (op[1:0] == 2'b11);
    endfunction

    function automatic logic [31:0] pack(input logic [2:0] t, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2,
                                         input logic signed [31:0] imm);
        logic [31:0] w;
        case (t)
            TYPE_R:  w = {f7, rs2, rs1, f3, rd, op};
            TYPE_I:  w = is_shift(t, op, f3) ? {f7, imm[4:0], rs1, f3, rd, op}
                                             : {imm[11:0], rs1, f3, rd, op};
            TYPE_S:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            TYPE_SB: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            TYPE_U:  w = {imm[31:12], rd, op};
            TYPE_UJ: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = '0;
        endcase
        return w;
    endfunction

    assign count_inc = {1'b0, count} + 17'd1;

    // Request capture: data only, no reset needed
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && in_ready) begin
            type_q   <= in_type;
            opcode_q <= in_opcode;
            funct3_q <= in_funct3;
            funct7_q <= in_funct7;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            imm_q    <= in_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            full       <= 1'b0;
            count      <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        state    <= ENCODE;
                    end
                end
                ENCODE: begin
                    mem_wdata <= pack(type_q, opcode_q, funct3_q, funct7_q,
                                      rd_q, rs1_q, rs2_q, imm_q);
                    if (is_legal(type_q, opcode_q, funct3_q, imm_q)) begin
                        mem_we <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        in_ready   <= !full;
                        state      <= IDLE;
                    end
                end
                WRITE: begin
                    // Word is held on the port until the memory takes it
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + ADDR_W'(4);
                        count    <= count_inc[15:0];
                        full     <= (count_inc == DEPTH_CNT);
                        in_ready <= (count_inc != DEPTH_CNT);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_instruction_encoder.sv
// Randomized bench for riscv_instruction_encoder: two instances (deep and DEPTH=2)
// checked against an arithmetic model of RV32I packing and legality.
module tb_riscv_instruction_encoder;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_SB = 3'd3,
                           T_U = 3'd4, T_UJ = 3'd5, T_X = 3'd6;
    localparam int unsigned DEP0 = 256, DEP1 = 2;
    localparam logic [31:0] BASE0 = 32'h0, BASE1 = 32'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid [2];
    logic        in_ready [2];
    logic [2:0]  in_type [2];
    logic [6:0]  in_opcode [2];
    logic [2:0]  in_funct3 [2];
    logic [6:0]  in_funct7 [2];
    logic [4:0]  in_rd [2];
    logic [4:0]  in_rs1 [2];
    logic [4:0]  in_rs2 [2];
    logic [31:0] in_imm [2];
    logic        mem_we [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic        mem_ack [2];
    logic        err [2];
    logic        err_sticky [2];
    logic        full [2];
    logic [15:0] count [2];

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_count [2];
    logic [31:0] exp_addr [2];
    bit          exp_sticky [2];
    int unsigned deps [2];
    logic [31:0] bases [2];

    riscv_instruction_encoder #(.ADDR_W(32), .BASE_ADDR(BASE0), .DEPTH(DEP0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_type(in_type[0]), .in_opcode(in_opcode[0]), .in_funct3(in_funct3[0]),
        .in_funct7(in_funct7[0]), .in_rd(in_rd[0]), .in_rs1(in_rs1[0]), .in_rs2(in_rs2[0]),
        .in_imm(in_imm[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack[0]), .err(err[0]),
        .err_sticky(err_sticky[0]), .full(full[0]), .count(count[0])
    );

    riscv_instruction_encoder #(.ADDR_W(32), .BASE_ADDR(BASE1), .DEPTH(DEP1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_type(in_type[1]), .in_opcode(in_opcode[1]), .in_funct3(in_funct3[1]),
        .in_funct7(in_funct7[1]), .in_rd(in_rd[1]), .in_rs1(in_rs1[1]), .in_rs2(in_rs2[1]),
        .in_imm(in_imm[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack[1]), .err(err[1]),
        .err_sticky(err_sticky[1]), .full(full[1]), .count(count[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: field placement by plain arithmetic, legality by integer ranges
    function automatic void model(input logic [2:0] t, input logic [6:0] op,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  output logic [31:0] w, output bit lg);
        int s;
        logic [31:0] o, d, a, b, c, g, m;
        s = int'($signed(imm));
        o = 32'(op); d = 32'(rd); a = 32'(rs1); b = 32'(rs2);
        c = 32'(f3); g = 32'(f7); m = imm;
        w = 32'h0;
        lg = 1'b1;
        case (t)
            T_R: w = o | d << 7 | c << 12 | a << 15 | b << 20 | g << 25;
            T_I: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    lg = (m < 32);
                    w = o | d << 7 | c << 12 | a << 15 | (m % 32) << 20 | g << 25;
                end else begin
                    lg = (s >= -2048 && s <= 2047);
                    w = o | d << 7 | c << 12 | a << 15 | (m % 4096) << 20;
                end
            end
            T_S: begin
                lg = (s >= -2048 && s <= 2047);
                w = o | (m % 32) << 7 | c << 12 | a << 15 | b << 20 | ((m / 32) % 128) << 25;
            end
            T_SB: begin
                lg = (s >= -4096 && s <= 4095) && (m % 2 == 0);
                w = o | ((m / 2048) % 2) << 7 | ((m / 2) % 16) << 8 | c << 12 | a << 15 |
                    b << 20 | ((m / 32) % 64) << 25 | ((m / 4096) % 2) << 31;
            end
            T_U: begin
                lg = (m % 4096 == 0);
                w = o | d << 7 | (m - m % 4096);
            end
            T_UJ: begin
                lg = (s >= -1048576 && s <= 1048575) && (m % 2 == 0);
                w = o | d << 7 | ((m / 4096) % 256) << 12 | ((m / 2048) % 2) << 20 |
                    ((m / 2) % 1024) << 21 | ((m / 1048576) % 2) << 31;
            end
            default: lg = 1'b0;
        endcase
        if (o % 4 != 3) lg = 1'b0;
    endfunction

    task automatic check_idle_state(input int d, input string tag);
        check_eq({tag, "_ready"}, in_ready[d], 1'b1);
        check_eq({tag, "_we"}, mem_we[d], 1'b0);
        check_eq({tag, "_addr"}, mem_addr[d], bases[d]);
        check_eq({tag, "_count"}, count[d], 0);
        check_eq({tag, "_full"}, full[d], 1'b0);
        check_eq({tag, "_sticky"}, err_sticky[d], 1'b0);
        check_eq({tag, "_err"}, err[d], 1'b0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_count[d] = 0;
            exp_addr[d] = bases[d];
            exp_sticky[d] = 1'b0;
        end
    endtask

    // One request from the negedge before the handshake to the return to IDLE
    task automatic do_req(input int d, input logic [2:0] t, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input int stall, input bit gv, input logic [31:0] gw, input bit abort);
        logic [31:0] w;
        bit lg;
        model(t, op, f3, f7, rd, rs1, rs2, imm, w, lg);
        if (gv) w = gw;
        check_eq("ready_before", in_ready[d], 1'b1);
        in_valid[d] = 1'b1; in_type[d] = t; in_opcode[d] = op; in_funct3[d] = f3;
        in_funct7[d] = f7; in_rd[d] = rd; in_rs1[d] = rs1; in_rs2[d] = rs2; in_imm[d] = imm;
        mem_ack[d] = (stall == 0) && !abort;
        @(negedge clk);
        in_valid[d] = 1'b0;
        check_eq("ready_encode", in_ready[d], 1'b0);
        check_eq("we_encode", mem_we[d], 1'b0);
        @(negedge clk);
        if (!lg) begin
            exp_sticky[d] = 1'b1;
            check_eq("err_pulse", err[d], 1'b1);
            check_eq("err_sticky", err_sticky[d], 1'b1);
            check_eq("we_illegal", mem_we[d], 1'b0);
            check_eq("ready_illegal", in_ready[d], 1'b1);
            @(negedge clk);
            check_eq("err_drop", err[d], 1'b0);
            check_eq("count_illegal", count[d], exp_count[d]);
            check_eq("addr_illegal", mem_addr[d], exp_addr[d]);
            mem_ack[d] = 1'b0;
        end else begin
            check_eq("we_write", mem_we[d], 1'b1);
            check_eq("addr_write", mem_addr[d], exp_addr[d]);
            check_eq("wdata_write", mem_wdata[d], w);
            if (abort) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                check_eq("abort_we", mem_we[d], 1'b0);
                check_eq("abort_count", count[d], 0);
                check_eq("abort_addr", mem_addr[d], bases[d]);
                check_eq("abort_ready", in_ready[d], 1'b1);
                check_eq("abort_sticky", err_sticky[d], 1'b0);
            end else begin
                for (int i = 0; i < stall; i++) begin
                    mem_ack[d] = 1'b0;
                    in_valid[d] = 1'($urandom);
                    @(negedge clk);
                    check_eq("stall_we", mem_we[d], 1'b1);
                    check_eq("stall_addr", mem_addr[d], exp_addr[d]);
                    check_eq("stall_wdata", mem_wdata[d], w);
                    check_eq("stall_ready", in_ready[d], 1'b0);
                    check_eq("stall_count", count[d], exp_count[d]);
                end
                in_valid[d] = 1'b0;
                mem_ack[d] = 1'b1;
                @(negedge clk);
                mem_ack[d] = 1'b0;
                exp_count[d]++;
                exp_addr[d] += 32'd4;
                check_eq("we_done", mem_we[d], 1'b0);
                check_eq("count_done", count[d], exp_count[d]);
                check_eq("addr_done", mem_addr[d], exp_addr[d]);
                check_eq("full_done", full[d], exp_count[d] == deps[d]);
                check_eq("ready_done", in_ready[d], exp_count[d] != deps[d]);
                check_eq("sticky_done", err_sticky[d], exp_sticky[d]);
            end
        end
    endtask

    logic [31:0] bnd [16] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094,
                              32'd4095, 32'd4096, -32'sd4096, -32'sd4098, 32'd31, 32'd32,
                              32'd1048574, 32'd1048576, -32'sd1048576, 32'h12345000, 32'h800};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t;
        logic [6:0] op;
        logic [31:0] imm;
        deps[0] = DEP0; deps[1] = DEP1;
        bases[0] = BASE0; bases[1] = BASE1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; in_type[d] = 0; in_opcode[d] = 0; in_funct3[d] = 0;
            in_funct7[d] = 0; in_rd[d] = 0; in_rs1[d] = 0; in_rs2[d] = 0;
            in_imm[d] = 0; mem_ack[d] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle_state(d, "rst");
            check_eq("rst_wdata", mem_wdata[d], 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_state(0, "post_rst");

        // Known-answer words
        do_req(0, T_I,  7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,         0, 1, 32'h00500093, 0);
        do_req(0, T_R,  7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,         0, 1, 32'h002081B3, 0);
        do_req(0, T_S,  7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,         0, 1, 32'h0020A423, 0);
        do_req(0, T_SB, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8,       0, 1, 32'hFE208CE3, 0);
        do_req(0, T_UJ, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16,        0, 1, 32'h010000EF, 0);
        do_req(0, T_U,  7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,  0, 1, 32'h123452B7, 0);
        do_req(0, T_I,  7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3,        0, 1, 32'h40315093, 0);
        // Long stall
        do_req(0, T_R,  7'h33, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 32'd0,        5, 0, 32'h0, 0);
        // Rejections
        do_req(0, T_I,  7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,      0, 0, 32'h0, 0);
        do_req(0, T_SB, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3,         0, 0, 32'h0, 0);
        do_req(0, T_U,  7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00000800,  0, 0, 32'h0, 0);
        do_req(0, T_X,  7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0,         0, 0, 32'h0, 0);
        do_req(0, T_R,  7'h32, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0,         0, 0, 32'h0, 0);

        for (int n = 0; n < 80; n++) begin
            t = 3'($urandom_range(0, 7));
            op = ($urandom % 8 == 0) ? 7'($urandom) : {5'($urandom), 2'b11};
            if (t == T_I && ($urandom % 2 == 1)) op = 7'h13;
            case ($urandom % 4)
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 80)) - 32'd40;
                2: imm = bnd[$urandom % 16];
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            do_req(0, t, op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), imm, $urandom_range(0, 3), 0, 32'h0, 0);
        end

        // Reset while a word is pending, then the next word lands at the base address
        do_req(0, T_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 32'h0, 1);
        do_req(0, T_I, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 2, 1, 32'h00700113, 0);
        check_eq("after_abort_addr", mem_addr[0], 32'd4);

        // Two-word instance fills up and then refuses further requests
        do_req(1, T_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 1, 32'h00500093, 0);
        do_req(1, T_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd1, 1, 1, 32'hFFF00093, 0);
        in_valid[1] = 1'b1;
        mem_ack[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("full_we", mem_we[1], 1'b0);
            check_eq("full_ready", in_ready[1], 1'b0);
            check_eq("full_flag", full[1], 1'b1);
            check_eq("full_count", count[1], 2);
            check_eq("full_addr", mem_addr[1], BASE1 + 32'd8);
        end
        in_valid[1] = 1'b0;
        mem_ack[1] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
